// File: rtl/irq_enc_pkg.sv
// Shared types and helpers for the irq_encoder block: FSM state encoding
// and a one-hot builder used to clear the acknowledged pending bit.
package irq_enc_pkg;

  localparam int STATE_W   = 1;
  localparam int MAX_LINES = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Returns a MAX_LINES-wide vector with only bit `index` set; all zero when
  // index falls outside the m request lines.
  function automatic logic [MAX_LINES-1:0] onehot(input int unsigned index,
                                                  input int unsigned m);
    logic [MAX_LINES-1:0] v;
    v = '0;
    if (index < m) begin
      v = MAX_LINES'(1) << index;
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_encoder_prio_encoder.sv
// Combinational priority picker over M mask bits. The search begins at `start`
// and wraps from M-1 back to 0; tie start to zero for fixed lowest-index-wins.
module prio_encoder #(
  parameter int N = 2,
  parameter int M = 3
) (
  input  logic [M-1:0] mask,
  input  logic [N-1:0] start,
  output logic [N-1:0] index,
  output logic         found
);

  localparam int          CODES  = 1 << N;
  localparam logic [N:0]  M_CODE = (N+1)'(M);

  logic [CODES-1:0] mask_ext;
  logic [N:0]       pos_w;
  logic [N-1:0]     pos;

  // Codes >= M read zero bits of the extended mask, so they are never picked.
  assign mask_ext = CODES'(mask);

  always_comb begin
    found = 1'b0;
    index = '0;
    pos_w = '0;
    pos   = '0;
    for (int k = 0; k < M; k++) begin
      pos_w = {1'b0, start} + (N+1)'(k);
      if (pos_w >= M_CODE) begin
        pos_w = pos_w - M_CODE;
      end
      pos = pos_w[N-1:0];
      if (!found && mask_ext[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/irq_encoder.sv
// Event-to-index encoder: rising edges on req set sticky pending bits; the
// selected pending index is presented on addr. Define IRQ_ENC_RR_EN for rotating priority.
module irq_encoder
  import irq_enc_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] req,
  input  logic         ena,
  output logic [N-1:0] addr,
  output logic         valid,
  input  logic         ready,
  output logic [M-1:0] pending
);

  if (M < 1 || M > (1 << N) || M > MAX_LINES) begin : g_param_err
    $error("irq_encoder: M must satisfy 1 <= M <= 2**N (and <= %0d)", MAX_LINES);
  end

  state_t               state;
  state_t               state_n;
  logic [M-1:0]         req_d;
  logic [M-1:0]         edges;
  logic [M-1:0]         clr_oh;
  logic [M-1:0]         cand;
  logic [M-1:0]         pending_n;
  logic [N-1:0]         addr_n;
  logic [N-1:0]         start;
  logic [N-1:0]         index;
  logic                 found;
  logic                 accept;
  logic [MAX_LINES-1:0] addr_oh;
  logic                 unused_oh;

  // Handshake: addr is granted while valid is high and stays frozen until the
  // consumer raises ready; a transfer happens on any clk edge with valid && ready.
  assign accept = valid & ready;
  assign valid  = (state == ST_HOLD);

  assign edges     = req & ~req_d;
  assign addr_oh   = onehot(32'(addr), unsigned'(M));
  assign unused_oh = ^addr_oh;
  assign clr_oh    = accept ? addr_oh[M-1:0] : '0;

  // A new edge on the line being acknowledged re-sets its bit, so no event is lost.
  assign cand      = pending & ~clr_oh;
  assign pending_n = cand | edges;

  prio_encoder #(
    .N (N),
    .M (M)
  ) u_prio (
    .mask  (cand),
    .start (start),
    .index (index),
    .found (found)
  );

`ifdef IRQ_ENC_RR_EN
  logic [N-1:0] rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (addr == N'(M - 1)) ? '0 : addr + 1'b1;
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr;
    case (state)
      ST_IDLE: begin
        if (ena && found) begin
          state_n = ST_HOLD;
          addr_n  = index;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (ena && found) begin
            addr_n = index;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      pending <= '0;
      req_d   <= '0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      pending <= pending_n;
      req_d   <= req;
    end
  end

endmodule

// File: tb/tb_irq_encoder.sv
// Directed bench for irq_encoder (N=2, M=3); expectations follow the rotating
// order when IRQ_ENC_RR_EN is defined and fixed priority otherwise.
module tb_irq_encoder;

  localparam int N = 2;
  localparam int M = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] req;
  logic         ena;
  logic         ready;
  logic [N-1:0] addr;
  logic         valid;
  logic [M-1:0] pending;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  irq_encoder #(
    .N (N),
    .M (M)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ena     (ena),
    .addr    (addr),
    .valid   (valid),
    .ready   (ready),
    .pending (pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // driver tasks: inputs change 1 ns after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; ena = 1'b1; ready = 1'b0;
    repeat (2) tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b expected 000", pending); end
    checks++; if (addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    rst = 1'b0;
    tick();
    checks++; if ({valid, pending} !== 4'b0111) begin errors++; $display("FAIL reset_release_capture: valid,pending got %b expected 0111", {valid, pending}); end
    tick();
    checks++; if ({valid, addr} !== 3'b100) begin errors++; $display("FAIL reset_release_grant: valid,addr got %b expected 100", {valid, addr}); end
    req = 3'b000; ready = 1'b1;
    tick();
    checks++; if ({valid, addr} !== 3'b101) begin errors++; $display("FAIL reset_drain1: valid,addr got %b expected 101", {valid, addr}); end
    tick();
    checks++; if ({valid, addr} !== 3'b110) begin errors++; $display("FAIL reset_drain2: valid,addr got %b expected 110", {valid, addr}); end
    tick();
    checks++; if ({valid, pending} !== 4'b0000) begin errors++; $display("FAIL reset_drain_end: valid,pending got %b expected 0000", {valid, pending}); end
    ready = 1'b0;
  endtask

  task automatic test_single_event();
    req = 3'b100; ready = 1'b1;
    tick();
    checks++; if ({valid, pending} !== 4'b0100) begin errors++; $display("FAIL single_capture: valid,pending got %b expected 0100", {valid, pending}); end
    req = 3'b000;
    tick();
    checks++; if ({valid, addr} !== 3'b110) begin errors++; $display("FAIL single_grant: valid,addr got %b expected 110", {valid, addr}); end
    tick();
    checks++; if ({valid, pending} !== 4'b0000) begin errors++; $display("FAIL single_done: valid,pending got %b expected 0000", {valid, pending}); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req = 3'b110;
    tick();
    req = 3'b000;
    tick();
    checks++; if ({valid, addr} !== 3'b101) begin errors++; $display("FAIL bp_grant: valid,addr got %b expected 101", {valid, addr}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({valid, addr} !== 3'b101) begin errors++; $display("FAIL bp_hold[%0d]: valid,addr got %b expected 101", i, {valid, addr}); end
    end
    ready = 1'b1;
    tick();
    checks++; if ({valid, addr} !== 3'b110) begin errors++; $display("FAIL bp_next: valid,addr got %b expected 110", {valid, addr}); end
    tick();
    checks++; if ({valid, pending} !== 4'b0000) begin errors++; $display("FAIL bp_done: valid,pending got %b expected 0000", {valid, pending}); end
    ready = 1'b0;
  endtask

  task automatic test_set_clear();
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();
    checks++; if ({valid, addr} !== 3'b101) begin errors++; $display("FAIL sc_grant: valid,addr got %b expected 101", {valid, addr}); end
    ready = 1'b1; req = 3'b010;
    tick();
    checks++; if ({valid, pending} !== 4'b0010) begin errors++; $display("FAIL sc_keep_pending: valid,pending got %b expected 0010", {valid, pending}); end
    tick();
    checks++; if ({valid, addr} !== 3'b101) begin errors++; $display("FAIL sc_regrant: valid,addr got %b expected 101", {valid, addr}); end
    req = 3'b000;
    tick();
    checks++; if ({valid, pending} !== 4'b0000) begin errors++; $display("FAIL sc_done: valid,pending got %b expected 0000", {valid, pending}); end
    ready = 1'b0;
  endtask

  task automatic test_ena();
    ena = 1'b0; req = 3'b011;
    tick();
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({valid, pending} !== 4'b0011) begin errors++; $display("FAIL ena_blocked[%0d]: valid,pending got %b expected 0011", i, {valid, pending}); end
    end
    ena = 1'b1;
    tick();
    checks++; if ({valid, addr} !== 3'b100) begin errors++; $display("FAIL ena_grant: valid,addr got %b expected 100", {valid, addr}); end
    ena = 1'b0; ready = 1'b1;
    tick();
    checks++; if ({valid, pending} !== 4'b0010) begin errors++; $display("FAIL ena_no_reload: valid,pending got %b expected 0010", {valid, pending}); end
    ena = 1'b1; ready = 1'b0;
    tick();
    checks++; if ({valid, addr} !== 3'b101) begin errors++; $display("FAIL ena_regrant: valid,addr got %b expected 101", {valid, addr}); end
    ready = 1'b1;
    tick();
    checks++; if ({valid, pending} !== 4'b0000) begin errors++; $display("FAIL ena_done: valid,pending got %b expected 0000", {valid, pending}); end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    checks++; if ({valid, addr} !== 3'b100) begin errors++; $display("FAIL rmid_grant: valid,addr got %b expected 100", {valid, addr}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({valid, pending} !== 4'b0000) begin errors++; $display("FAIL rmid_async_drop: valid,pending got %b expected 0000", {valid, pending}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({valid, pending} !== 4'b0000) begin errors++; $display("FAIL rmid_event_lost: valid,pending got %b expected 0000", {valid, pending}); end
  endtask

  // all three lines toggle every other cycle while the consumer accepts every cycle
  task automatic test_back_to_back();
    logic [N-1:0] exp_a;
    int n;
`ifdef IRQ_ENC_RR_EN
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
`else
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
`endif
    ena = 1'b1; ready = 1'b1; req = 3'b111;
    tick();
    checks++; if ({valid, pending} !== 4'b0111) begin errors++; $display("FAIL b2b_capture: valid,pending got %b expected 0111", {valid, pending}); end
    req = 3'b000;
    for (int t = 2; t <= 9; t++) begin
      tick();
      exp_a = exp_q.pop_front();
      checks++; if ({valid, addr} !== {1'b1, exp_a}) begin errors++; $display("FAIL b2b_grant[%0d]: valid,addr got %b expected %b", t, {valid, addr}, {1'b1, exp_a}); end
      req = ((t + 1) % 2 == 1) ? 3'b111 : 3'b000;
    end
    req = 3'b000;
    n = 0;
    while (valid && n < 12) begin
      tick();
      n++;
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_timeout: valid got %b expected 0 after %0d cycles", valid, n); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL b2b_drain_pending: got %b expected 000", pending); end
    ready = 1'b0;
  endtask

  // test sequence and final report
  initial begin
    rst = 1'b1; req = '0; ena = 1'b1; ready = 1'b0;
    test_reset();
    idle_gap();
    test_single_event();
    idle_gap();
    test_backpressure();
    idle_gap();
    test_set_clear();
    idle_gap();
    test_ena();
    idle_gap();
    test_reset_mid();
    idle_gap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
